// File: rtl/instruction_fetch.sv
// Instruction fetch front end.
// Issues one word address per cycle to a synchronous instruction memory. A
// single skid entry holds the in-flight response when decode stalls, and a
// redirect squashes everything and restarts fetch at the branch target.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_ir,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_ir,
    output logic [31:0]       fetch_count
);

    // EMPTY: nothing to present; STREAM: response arriving from memory this
    // cycle; HOLD: a response parked in the skid entry. Encoding the two
    // flags as one state makes "skid and response both valid" unreachable.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        STREAM = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rsp_pc;
    logic [31:0] skid_pc;
    logic [31:0] skid_ir;
    logic [31:0] redirect_base;
    logic        rsp_pend;
    logic        skid_v;
    logic        issue;
    logic        accept;
    logic        capture;
    logic        redirect_eff;

    assign rsp_pend      = (state_q == STREAM);
    assign skid_v        = (state_q == HOLD);
    // A redirect seen while reset is held must not disturb the reset address.
    assign redirect_eff  = redirect_valid & ~rst;
    assign redirect_base = {redirect_pc[31:2], 2'b00};
    assign issue         = redirect_eff | ~stall;
    assign imem_addr     = redirect_eff ? redirect_pc[ADDR_W+1:2] : pc_q[ADDR_W+1:2];

    // Next state, next PC and the presented instruction.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        if_valid = 1'b0;
        if_pc    = rsp_pc;
        if_ir    = imem_ir;
        capture  = 1'b0;

        if (skid_v) begin
            if_pc = skid_pc;
            if_ir = skid_ir;
        end
        if (!redirect_eff) begin
            if_valid = skid_v | rsp_pend;
        end

        if (redirect_eff) begin
            // Squash skid and in-flight response; restart at the target.
            pc_d    = redirect_base + 32'd4;
            state_d = STREAM;
        end else if (!stall) begin
            pc_d    = pc_q + 32'd4;
            state_d = STREAM;
        end else begin
            case (state_q)
                STREAM: begin
                    // Memory data is only valid this cycle: park it.
                    state_d = HOLD;
                    capture = 1'b1;
                end
                HOLD:    state_d = HOLD;
                default: state_d = EMPTY;
            endcase
        end
    end

    assign accept = if_valid & ~stall;

    // Control state and PC, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Response PC and skid payload; only meaningful when the state says so.
    always_ff @(posedge clk) begin
        if (issue) begin
            rsp_pc <= redirect_eff ? redirect_base : pc_q;
        end
        if (capture) begin
            skid_pc <= rsp_pc;
            skid_ir <= imem_ir;
        end
    end

    // Count instructions handed to decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'd0;
        end else if (accept) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table with a scoreboard of
// instructions decode is expected to accept, plus hand-written reset sequences.
module tb_instruction_fetch;

    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_ir;
    logic              stall = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = 32'd0;
    logic              if_valid;
    logic [31:0]       if_pc;
    logic [31:0]       if_ir;
    logic [31:0]       fetch_count;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_ir        (imem_ir),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_ir          (if_ir),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    // Synchronous memory with word[i] = i.
    always @(posedge clk) imem_ir <= {{(32-ADDR_W){1'b0}}, imem_addr};

    typedef struct {
        logic              stall;
        logic              redir;
        logic [31:0]       rpc;
        logic              exp_valid;
        logic [31:0]       exp_pc;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } instr_t;

    vec_t   vecs[23];
    instr_t sb_q[$];
    int     n_total = 0;
    int     n_pass  = 0;
    int     exp_count = 0;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        logic [ADDR_W-1:0] a;
        a = pc[ADDR_W+1:2];
        return {{(32-ADDR_W){1'b0}}, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_expected(input logic [31:0] pc);
        instr_t t;
        t.pc = pc;
        t.ir = word_of(pc);
        sb_q.push_back(t);
    endtask

    // When decode consumes an instruction, it must be the next one expected.
    task automatic monitor_accept(input string tag);
        instr_t t;
        if (if_valid === 1'b1 && stall === 1'b0) begin
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL %s.sb_accept: got pc %h, expected no acceptance", tag, if_pc);
            end else begin
                n_pass++;
                t = sb_q.pop_front();
                check({tag, ".sb_pc"}, if_pc, t.pc);
                check({tag, ".sb_ir"}, if_ir, t.ir);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //            stall redir rpc           valid pc            addr
        vecs[0]  = '{1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       15'h0};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       15'h1};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       15'h2};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       15'h3};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       15'h3};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       15'h3};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       15'h3};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       15'h4};
        vecs[8]  = '{1'b0, 1'b1, 32'h100,     1'b0, 32'h0,       15'h40};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h100,     15'h41};
        vecs[10] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h104,     15'h42};
        vecs[11] = '{1'b1, 1'b1, 32'h203,     1'b0, 32'h0,       15'h80};
        vecs[12] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h200,     15'h81};
        vecs[13] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h200,     15'h81};
        vecs[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     15'h81};
        vecs[15] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h204,     15'h82};
        vecs[16] = '{1'b0, 1'b1, 32'h1FFFC,   1'b0, 32'h0,       15'h7FFF};
        vecs[17] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h1FFFC,   15'h0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h20000,   15'h1};
        vecs[19] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h20004,   15'h2};
        vecs[20] = '{1'b1, 1'b0, 32'h0,       1'b1, 32'h20008,   15'h3};
        vecs[21] = '{1'b0, 1'b1, 32'h40,      1'b0, 32'h0,       15'h10};
        vecs[22] = '{1'b0, 1'b0, 32'h0,       1'b1, 32'h40,      15'h11};

        // Reset state while rst is held.
        @(negedge clk);
        check("rst.if_valid", {31'd0, if_valid}, 32'd0);
        check("rst.fetch_count", fetch_count, 32'd0);
        check("rst.imem_addr", {17'd0, imem_addr}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            @(posedge clk);
            #1;
            rst            = 1'b0;
            stall          = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            if (vecs[i].exp_valid && !vecs[i].stall) push_expected(vecs[i].exp_pc);
            @(negedge clk);
            check($sformatf("v%0d.if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d.if_pc", i), if_pc, vecs[i].exp_pc);
                check($sformatf("v%0d.if_ir", i), if_ir, word_of(vecs[i].exp_pc));
            end
            check($sformatf("v%0d.imem_addr", i), {17'd0, imem_addr}, {17'd0, vecs[i].exp_addr});
            check($sformatf("v%0d.fetch_count", i), fetch_count, exp_count);
            monitor_accept($sformatf("v%0d", i));
            if (vecs[i].exp_valid && !vecs[i].stall) exp_count++;
        end

        // Asynchronous reset mid-stream: outputs drop before any clock edge.
        @(posedge clk);
        #1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("pre_rst.if_valid", {31'd0, if_valid}, 32'd1);
        check("pre_rst.if_pc", if_pc, 32'h44);
        check("pre_rst.fetch_count", fetch_count, exp_count);
        rst = 1'b1;
        #1;
        check("async_rst.if_valid", {31'd0, if_valid}, 32'd0);
        check("async_rst.fetch_count", fetch_count, 32'd0);
        check("async_rst.imem_addr", {17'd0, imem_addr}, 32'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        check("rst_redir.imem_addr", {17'd0, imem_addr}, 32'd0);
        check("rst_redir.if_valid", {31'd0, if_valid}, 32'd0);

        // Restart: RESET_PC issued in the first cycle, presented in the next.
        @(posedge clk);
        #1;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("restart0.if_valid", {31'd0, if_valid}, 32'd0);
        check("restart0.imem_addr", {17'd0, imem_addr}, 32'd0);
        @(posedge clk);
        #1;
        push_expected(32'h0);
        @(negedge clk);
        check("restart1.if_valid", {31'd0, if_valid}, 32'd1);
        check("restart1.if_pc", if_pc, 32'h0);
        check("restart1.fetch_count", fetch_count, 32'd0);
        monitor_accept("restart1");
        @(posedge clk);
        #1;
        push_expected(32'h4);
        @(negedge clk);
        check("restart2.if_pc", if_pc, 32'h4);
        check("restart2.fetch_count", fetch_count, 32'd1);
        monitor_accept("restart2");

        check("sb.leftover", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
